// File: rtl/instr_encoder_stream.sv
// Packs decoded Frost32 instruction field bundles into 32-bit words and streams
// them into instruction memory at consecutive addresses, with error accounting.
module instr_encoder_stream #(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_group,
    input  logic [3:0]        in_ra,
    input  logic [3:0]        in_rb,
    input  logic [3:0]        in_rc,
    input  logic [3:0]        in_opcode,
    input  logic [15:0]       in_imm_val,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   word_count,
    output logic [7:0]        err_count,
    output logic              err_flag,
    output logic              full
);

    localparam logic [ADDR_W:0]   MAX_CNT  = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr;
    logic [31:0]       enc_word;
    logic              legal;
    logic              accept;

    assign full     = (word_count == MAX_CNT);
    assign in_ready = !rst && !start && !full && (!mem_we || mem_ready);
    assign accept   = in_valid && in_ready;

    // G5 carries a signed 12-bit immediate, so the top five bits must be a pure sign extension.
    always_comb begin
        legal = 1'b0;
        if (in_group < 4'd5)
            legal = 1'b1;
        else if (in_group == 4'd5)
            legal = (in_imm_val[15:11] == 5'h1F) || (in_imm_val[15:11] == 5'h00);
    end

    always_comb begin
        enc_word = 32'h0;
        case (in_group)
            4'd1, 4'd2: enc_word = {in_group, in_ra, in_rb, in_opcode, in_imm_val};
            4'd5:       enc_word = {in_group, in_ra, in_rb, in_rc, in_opcode, in_imm_val[11:0]};
            default:    enc_word = {in_group, in_ra, in_rb, in_rc, in_opcode, 12'h000};
        endcase
    end

    // Clearing mem_we before the load lets an acceptance in the same cycle refill the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            addr       <= '0;
            word_count <= '0;
            err_count  <= 8'd0;
            err_flag   <= 1'b0;
        end else if (start) begin
            mem_we     <= 1'b0;
            addr       <= base_addr;
            word_count <= '0;
            err_count  <= 8'd0;
            err_flag   <= 1'b0;
        end else begin
            if (mem_we && mem_ready)
                mem_we <= 1'b0;
            if (accept) begin
                if (legal) begin
                    mem_we     <= 1'b1;
                    mem_addr   <= addr;
                    mem_wdata  <= enc_word;
                    addr       <= addr + ADDR_ONE;
                    word_count <= word_count + CNT_ONE;
                end else begin
                    err_flag <= 1'b1;
                    if (err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_stream.sv
// Scoreboard bench: expected words are queued as bundles are driven and popped
// when the encoder's memory write handshake completes.
module tb_instr_encoder_stream;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  group, ra, rb, rc, opcode;
    logic [15:0] imm;

    logic        start_a, in_valid_a, in_ready_a, mem_we_a, mem_ready_a, err_flag_a, full_a;
    logic [11:0] base_a, mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [12:0] word_count_a;
    logic [7:0]  err_count_a;

    logic        start_b, in_valid_b, in_ready_b, mem_we_b, mem_ready_b, err_flag_b, full_b;
    logic [1:0]  base_b, mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [2:0]  word_count_b;
    logic [7:0]  err_count_b;

    exp_t qa[$];
    exp_t qb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    instr_encoder_stream #(.ADDR_W(12), .MAX_WORDS(4096)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_group(group), .in_ra(ra), .in_rb(rb), .in_rc(rc), .in_opcode(opcode), .in_imm_val(imm),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_ready(mem_ready_a),
        .word_count(word_count_a), .err_count(err_count_a), .err_flag(err_flag_a), .full(full_a)
    );

    instr_encoder_stream #(.ADDR_W(2), .MAX_WORDS(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_group(group), .in_ra(ra), .in_rb(rb), .in_rc(rc), .in_opcode(opcode), .in_imm_val(imm),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_ready(mem_ready_b),
        .word_count(word_count_b), .err_count(err_count_b), .err_flag(err_flag_b), .full(full_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference packing built field by field from the instruction format table.
    function automatic logic [31:0] model_word(input logic [3:0] g, input logic [3:0] a, input logic [3:0] b,
                                               input logic [3:0] c, input logic [3:0] op, input logic [15:0] iv);
        logic [31:0] w;
        w = 32'h0;
        w[31:28] = g;
        w[27:24] = a;
        w[23:20] = b;
        if (g == 4'd1 || g == 4'd2) begin
            w[19:16] = op;
            w[15:0]  = iv;
        end else begin
            w[19:16] = c;
            w[15:12] = op;
            if (g == 4'd5) w[11:0] = iv[11:0];
        end
        return w;
    endfunction

    task automatic applyStimulus(input logic [3:0] g, input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] c, input logic [3:0] op, input logic [15:0] iv);
        group = g; ra = a; rb = b; rc = c; opcode = op; imm = iv;
    endtask

    task automatic push_a(input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        qa.push_back(e);
    endtask

    // One clock: look at the write handshake shortly before the rising edge, then return at the falling edge.
    task automatic step();
        exp_t e;
        #3;
        if (mem_we_a && mem_ready_a) begin
            total_cnt++;
            if (qa.size() == 0)
                $display("[TB] FAIL write_a: got addr=%h data=%h, required no write", mem_addr_a, mem_wdata_a);
            else begin
                e = qa.pop_front();
                if (mem_addr_a !== e.addr || mem_wdata_a !== e.data)
                    $display("[TB] FAIL write_a: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr_a, mem_wdata_a, e.addr, e.data);
                else pass_cnt++;
            end
        end
        if (mem_we_b && mem_ready_b) begin
            total_cnt++;
            if (qb.size() == 0)
                $display("[TB] FAIL write_b: got addr=%h data=%h, required no write", mem_addr_b, mem_wdata_b);
            else begin
                e = qb.pop_front();
                if (mem_addr_b !== e.addr[1:0] || mem_wdata_b !== e.data)
                    $display("[TB] FAIL write_b: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr_b, mem_wdata_b, e.addr[1:0], e.data);
                else pass_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 0; in_valid_a = 0; mem_ready_a = 0; base_a = '0;
        start_b = 0; in_valid_b = 0; mem_ready_b = 0; base_b = '0;
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (in_ready_a !== 1'b0 || mem_we_a !== 1'b0 || mem_addr_a !== 12'h0 || mem_wdata_a !== 32'h0)
            $display("[TB] FAIL reset_mem: got rdy=%b we=%b addr=%h data=%h, required 0 0 000 00000000",
                     in_ready_a, mem_we_a, mem_addr_a, mem_wdata_a);
        else pass_cnt++;
        total_cnt++;
        if (word_count_a !== 13'd0 || err_count_a !== 8'd0 || err_flag_a !== 1'b0 || full_a !== 1'b0)
            $display("[TB] FAIL reset_cnt: got wc=%0d ec=%0d ef=%b full=%b, required 0 0 0 0",
                     word_count_a, err_count_a, err_flag_a, full_a);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (in_ready_a !== 1'b1) $display("[TB] FAIL ready_after_reset: got %b, required 1", in_ready_a);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        mem_ready_a = 1'b1;
        applyStimulus(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 16'h0);
        in_valid_a = 1'b1;
        push_a(12'h000, 32'h01234000);
        step();
        in_valid_a = 1'b0;
        total_cnt++;
        if (mem_we_a !== 1'b1 || mem_addr_a !== 12'h000 || mem_wdata_a !== 32'h01234000 || word_count_a !== 13'd1)
            $display("[TB] FAIL basic_g0: got we=%b addr=%h data=%h wc=%0d, required 1 000 01234000 1",
                     mem_we_a, mem_addr_a, mem_wdata_a, word_count_a);
        else pass_cnt++;
        step();
    endtask

    task automatic test_start_imm();
        base_a = 12'h100;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        total_cnt++;
        if (word_count_a !== 13'd0 || mem_we_a !== 1'b0)
            $display("[TB] FAIL start_clear: got wc=%0d we=%b, required 0 0", word_count_a, mem_we_a);
        else pass_cnt++;
        applyStimulus(4'd1, 4'd5, 4'd6, 4'd9, 4'd2, 16'hBEEF);
        in_valid_a = 1'b1;
        push_a(12'h100, 32'h1562BEEF);
        step();
        applyStimulus(4'd5, 4'd1, 4'd2, 4'd3, 4'd5, 16'hFFF8);
        push_a(12'h101, 32'h51235FF8);
        step();
        in_valid_a = 1'b0;
        step();
        total_cnt++;
        if (word_count_a !== 13'd2) $display("[TB] FAIL start_wc: got %0d, required 2", word_count_a);
        else pass_cnt++;
    endtask

    task automatic test_reject();
        applyStimulus(4'd5, 4'd1, 4'd1, 4'd1, 4'd1, 16'h0800);
        in_valid_a = 1'b1;
        step();
        applyStimulus(4'd7, 4'd1, 4'd1, 4'd1, 4'd1, 16'h0);
        step();
        in_valid_a = 1'b0;
        total_cnt++;
        if (err_count_a !== 8'd2 || err_flag_a !== 1'b1 || mem_we_a !== 1'b0 || word_count_a !== 13'd2)
            $display("[TB] FAIL reject: got ec=%0d ef=%b we=%b wc=%0d, required 2 1 0 2",
                     err_count_a, err_flag_a, mem_we_a, word_count_a);
        else pass_cnt++;
        applyStimulus(4'd3, 4'hA, 4'hB, 4'hC, 4'hD, 16'hFFFF);
        in_valid_a = 1'b1;
        push_a(12'h102, model_word(4'd3, 4'hA, 4'hB, 4'hC, 4'hD, 16'hFFFF));
        step();
        in_valid_a = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        mem_ready_a = 1'b0;
        applyStimulus(4'd4, 4'd1, 4'd1, 4'd1, 4'd1, 16'h0);
        in_valid_a = 1'b1;
        push_a(12'h103, 32'h41111000);
        step();
        applyStimulus(4'd0, 4'd7, 4'd7, 4'd7, 4'd7, 16'h0);
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (mem_we_a !== 1'b1 || mem_addr_a !== 12'h103 || mem_wdata_a !== 32'h41111000 || in_ready_a !== 1'b0)
                $display("[TB] FAIL stall_hold: cycle %0d got we=%b addr=%h data=%h rdy=%b, required 1 103 41111000 0",
                         i, mem_we_a, mem_addr_a, mem_wdata_a, in_ready_a);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (word_count_a !== 13'd4) $display("[TB] FAIL stall_wc: got %0d, required 4", word_count_a);
        else pass_cnt++;
        mem_ready_a = 1'b1;
        push_a(12'h104, 32'h07777000);
        step();
        applyStimulus(4'd2, 4'd2, 4'd3, 4'd0, 4'd4, 16'h1234);
        push_a(12'h105, 32'h22341234);
        total_cnt++;
        if (mem_we_a !== 1'b1 || mem_addr_a !== 12'h104)
            $display("[TB] FAIL no_bubble1: got we=%b addr=%h, required 1 104", mem_we_a, mem_addr_a);
        else pass_cnt++;
        step();
        in_valid_a = 1'b0;
        total_cnt++;
        if (mem_we_a !== 1'b1 || mem_addr_a !== 12'h105)
            $display("[TB] FAIL no_bubble2: got we=%b addr=%h, required 1 105", mem_we_a, mem_addr_a);
        else pass_cnt++;
        step();
        total_cnt++;
        if (word_count_a !== 13'd6 || mem_we_a !== 1'b0)
            $display("[TB] FAIL b2b_end: got wc=%0d we=%b, required 6 0", word_count_a, mem_we_a);
        else pass_cnt++;
    endtask

    task automatic test_wrap_full();
        exp_t e;
        base_b = 2'd3;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        mem_ready_b = 1'b1;
        in_valid_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'd0, 4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3), 16'h0);
            e.addr = 12'((3 + i) % 4);
            e.data = model_word(4'd0, 4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3), 16'h0);
            qb.push_back(e);
            step();
        end
        total_cnt++;
        if (full_b !== 1'b1 || in_ready_b !== 1'b0 || word_count_b !== 3'd4)
            $display("[TB] FAIL full_set: got full=%b rdy=%b wc=%0d, required 1 0 4", full_b, in_ready_b, word_count_b);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (in_ready_b !== 1'b0 || word_count_b !== 3'd4 || mem_we_b !== 1'b0)
            $display("[TB] FAIL full_hold: got rdy=%b wc=%0d we=%b, required 0 4 0", in_ready_b, word_count_b, mem_we_b);
        else pass_cnt++;
        in_valid_b = 1'b0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        #1;
        total_cnt++;
        if (full_b !== 1'b0 || word_count_b !== 3'd0 || in_ready_b !== 1'b1)
            $display("[TB] FAIL full_clear: got full=%b wc=%0d rdy=%b, required 0 0 1", full_b, word_count_b, in_ready_b);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_start_flush();
        mem_ready_a = 1'b0;
        applyStimulus(4'd0, 4'd9, 4'd9, 4'd9, 4'd9, 16'h0);
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        total_cnt++;
        if (mem_we_a !== 1'b1) $display("[TB] FAIL flush_pending: got we=%b, required 1", mem_we_a);
        else pass_cnt++;
        base_a = 12'h200;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        total_cnt++;
        if (mem_we_a !== 1'b0 || word_count_a !== 13'd0 || err_count_a !== 8'd0 || err_flag_a !== 1'b0)
            $display("[TB] FAIL flush_clear: got we=%b wc=%0d ec=%0d ef=%b, required 0 0 0 0",
                     mem_we_a, word_count_a, err_count_a, err_flag_a);
        else pass_cnt++;
        mem_ready_a = 1'b1;
        step();
        step();
        applyStimulus(4'd3, 4'd1, 4'd0, 4'd2, 4'd6, 16'h0);
        in_valid_a = 1'b1;
        push_a(12'h200, model_word(4'd3, 4'd1, 4'd0, 4'd2, 4'd6, 16'h0));
        step();
        in_valid_a = 1'b0;
        step();
        total_cnt++;
        if (word_count_a !== 13'd1) $display("[TB] FAIL flush_wc: got %0d, required 1", word_count_a);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        mem_ready_a = 1'b0;
        applyStimulus(4'd4, 4'd2, 4'd2, 4'd2, 4'd2, 16'h0);
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        total_cnt++;
        if (mem_we_a !== 1'b1) $display("[TB] FAIL areset_pending: got we=%b, required 1", mem_we_a);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (mem_we_a !== 1'b0 || mem_addr_a !== 12'h0 || word_count_a !== 13'd0)
            $display("[TB] FAIL areset_drop: got we=%b addr=%h wc=%0d, required 0 000 0", mem_we_a, mem_addr_a, word_count_a);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        mem_ready_a = 1'b1;
        step();
        applyStimulus(4'd5, 4'd3, 4'd4, 4'd5, 4'd6, 16'h07FF);
        in_valid_a = 1'b1;
        push_a(12'h000, model_word(4'd5, 4'd3, 4'd4, 4'd5, 4'd6, 16'h07FF));
        step();
        in_valid_a = 1'b0;
        step();
        total_cnt++;
        if (qa.size() != 0 || qb.size() != 0)
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", qa.size(), qb.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_imm();
        test_reject();
        test_back_to_back();
        test_wrap_full();
        test_start_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_encoder_stream.md
Name: instr_encoder_stream

Overview:
- Converts a stream of decoded-form instruction field bundles into packed 32-bit Frost32 instruction words.
- Writes the words sequentially into instruction memory. It is the inverse of the instruction decode path.
- Used by the boot/program-loader path and by testbenches to build program images from field-level descriptions.
- Holds a valid/ready input side, a one-entry output register with memory backpressure, an address counter, and error accounting.

Parameters:
- ADDR_W, 12, instruction memory word-address width.
- MAX_WORDS, 4096, words accepted after a start before full asserts (1..2^ADDR_W).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: load base address, clear counters and flags, flush pending write.
- base_addr  in  ADDR_W  first write address, sampled on start.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- in_group  in  4  instruction group.
- in_ra, in_rb, in_rc  in  4 each  register indices.
- in_opcode  in  4  opcode within group.
- in_imm_val  in  16  immediate; 2's complement for group 5.
- mem_we  out  1  write request, held until mem_ready.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  memory accepts the write this cycle when mem_we && mem_ready.
- word_count  out  ADDR_W+1  words written since start/reset.
- err_count  out  8  rejected bundles; saturates at 255.
- err_flag  out  1  sticky; set on first rejection.
- full  out  1  accepted-word count == MAX_WORDS.

Behaviour:
- Reset: in_ready=0 during rst; outputs mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, err_count=0, err_flag=0, full=0. Internal address=0.
- After reset, the block accepts input at address 0 without needing start.
- Encoding (unused bits zero):
  - G0, G3, G4: [31:28]=group, [27:24]=ra, [23:20]=rb, [19:16]=rc, [15:12]=opcode, [11:0]=0.
  - G1, G2: [31:28]=group, [27:24]=ra, [23:20]=rb, [19:16]=opcode, [15:0]=imm; rc ignored.
  - G5: [31:28]=5, [27:24]=ra, [23:20]=rb, [19:16]=rc, [15:12]=opcode, [11:0]=imm[11:0]. Legal only if imm[15:11] are all equal (value representable in signed 12 bits).
- Rejection: group >= 6, or an out-of-range G5 immediate.
  - The bundle is consumed; no write and no address advance.
  - err_count increments (saturating) and err_flag sets.
  - Rejections also count toward nothing else.
- in_ready = !rst && !start && !full && (!mem_we || mem_ready). Pass-through: a new word may be loaded in the same cycle the held word is accepted.
- Latency: a bundle accepted at edge N produces mem_we=1 with mem_addr/mem_wdata stable from after edge N until the edge where mem_ready=1.
- Address and count:
  - The internal address increments on each legal acceptance.
  - mem_addr wraps modulo 2^ADDR_W.
  - word_count increments on each legal acceptance.
  - full = (word_count == MAX_WORDS); once full, in_ready stays 0 until start or reset.
- start:
  - mem_we clears next cycle; a pending word is dropped.
  - Address <= base_addr; word_count, err_count, err_flag and full clear.
  - in_valid in the start cycle is not accepted.
- mem_ready while mem_we=0 is ignored.
- Asynchronous reset mid-write drops the pending word immediately.

Test Plan:
- Reset, then G0 ra=1 rb=2 rc=3 op=4 with mem_ready=1 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x01234000; word_count=1.
- start with base_addr=0x100, then G1 ra=5 rb=6 op=2 imm=0xBEEF, then G5 ra=1 rb=2 rc=3 op=5 imm=0xFFF8 -> writes 0x1562BEEF @0x100, then 0x51235FF8 @0x101.
- G5 imm=0x0800, then group=7 -> both consumed, no mem_we; err_count=2, err_flag=1; address unchanged, so the next legal word goes to the same address.
- mem_ready=0 for 5 cycles with word pending -> mem_we, mem_addr, mem_wdata held constant; in_ready=0; no second acceptance. Then mem_ready=1 with in_valid -> back-to-back writes at consecutive addresses, no bubble.
- MAX_WORDS=4, ADDR_W=2, base_addr=3 -> writes at addresses 3, 0, 1, 2; full=1 after the 4th acceptance; in_ready=0. Then start clears full.
- start asserted while mem_we=1 and mem_ready=0 -> mem_we=0 next cycle, word_count=0, and the pending word is never written.
